udp_tx: RTL and testbench
=========================

UDP_TX -- requirements
Module: udp_tx

Interface
REQ-001 SHALL have parameters SRC_MAC (48b, 02:00:00:00:00:01), DST_MAC (48b, FF:FF:FF:FF:FF:FF) and SRC_IP (32b, 192.168.1.10).
REQ-002 SHALL have parameters DST_IP (32b, 192.168.1.20), SRC_PORT (16b, 5000), DST_PORT (16b, 5001) and TTL (8b, 64).
REQ-003 main_clk  in  1  sole clock, all logic on rising edge.
REQ-004 main_rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to send a datagram; ignored while busy.
REQ-006 tx_len  in  11  UDP payload byte count, sampled with start; legal range 1..1472.
REQ-007 pay_byte  in  8  payload byte.
REQ-008 pay_valid  in  1  pay_byte is valid.
REQ-009 pay_ready  out  1  block accepts pay_byte this cycle.
REQ-010 eth_byte  out  8  wire byte, preamble through FCS.
REQ-011 eth_valid  out  1  eth_byte is valid.
REQ-012 eth_ready  in  1  downstream accepts eth_byte.
REQ-013 busy  out  1  high from accepted start until IFG ends.
REQ-014 done  out  1  one-cycle pulse after the last FCS byte is accepted.
REQ-015 len_err  out  1  one-cycle pulse when start arrives with tx_len 0 or >1472.

Function
REQ-016 States SHALL be IDLE, CSUM1, CSUM2, PREAMBLE, SFD, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, PAD, FCS, IFG.
REQ-017 IDLE: legal start -> latch tx_len, busy=1, go to CSUM1; illegal start -> len_err, stay IDLE, no output.
REQ-018 CSUM1: 20-bit sum = constant-field sum + total_len (tx_len+28) + ident; CSUM2: fold carries twice, invert -> 16-bit checksum.
REQ-019 Wire order: 7x 0x55, 0xD5, DST_MAC, SRC_MAC, 0x0800, IPv4 header, UDP header, payload, pad, FCS, all MSB-byte first except FCS.
REQ-020 IPv4 header: 0x45, 0x00, total_len, ident, 0x4000 (DF), TTL, 0x11, checksum, SRC_IP, DST_IP.
REQ-021 UDP header: SRC_PORT, DST_PORT, tx_len+8, checksum 0x0000.
REQ-022 ident SHALL be 16b, reset 0, incremented on each done, wrapping 0xFFFF->0x0000.
REQ-023 Output register advances when !eth_valid || eth_ready; eth_byte/eth_valid held stable while eth_valid && !eth_ready.
REQ-024 pay_ready = (state==PAYLOAD) && (!eth_valid || eth_ready); exactly tx_len payload bytes consumed per frame.
REQ-025 pay_valid low in PAYLOAD SHALL insert a bubble (eth_valid=0), never corrupt data.
REQ-026 tx_len<18 -> PAD emits 18-tx_len zero bytes, so the Ethernet payload is 46 bytes.
REQ-027 FCS: CRC-32 over DST_MAC..last pad byte, reflected poly 0xEDB88320, init 0xFFFFFFFF, output inverted, LSB byte first.
REQ-028 IFG: 12 cycles with eth_valid=0, then IDLE, busy=0; start during busy SHALL be dropped.
REQ-029 start and done never coincide usefully: start in done cycle is ignored (busy still 1).

Reset
REQ-030 main_rst SHALL force IDLE, eth_valid=0, pay_ready=0, busy=0, done=0, len_err=0, eth_byte=0x00, ident=0, CRC=0xFFFFFFFF.
REQ-031 Reset mid-frame SHALL abort immediately (eth_valid=0 next cycle); no done pulse; partial frame abandoned.

Structure
REQ-032 Shared package udp_pkg SHALL hold the state enum, ETHERTYPE_IPV4=0x0800, PROTO_UDP=0x11, PREAMBLE=0x55, SFD=0xD5, MAX_PAYLOAD=1472, MIN_ETH_PAYLOAD=46, IFG_CYCLES=12.
REQ-033 Sub-module crc32_eth SHALL compute the byte-wise CRC with inputs clk, rst, init, en, data[7:0] and output crc[31:0].

Verification
REQ-034 tx_len=18, payload 0x00..0x11, eth_ready=1 -> 72 bytes: 55x7, D5, ethertype 08 00 at bytes 20-21, IP total_len 0x002E, UDP len 0x001A, no pad; done once.
REQ-035 tx_len=1, payload 0xAB -> 17 zero pad bytes after 0xAB, 72 bytes total; FCS matches a software CRC-32 model.
REQ-036 tx_len=1472 -> 1526 bytes; IP total_len 0x05DC; one's-complement sum of the 10 header words = 0xFFFF; second frame has ident=1.
REQ-037 tx_len=0 and tx_len=1473 -> len_err pulse, busy stays 0, eth_valid never asserted.
REQ-038 Random eth_ready and pay_valid toggling with tx_len=64 -> byte sequence identical to the no-stall run; eth_byte stable during every stall.
REQ-039 main_rst asserted at payload byte 10 -> eth_valid=0 next cycle, no done; next start yields a complete, correct frame with ident=0.

Source files
------------

// File: rtl/udp_pkg.sv
// rtl/udp_pkg.sv - shared states and constants for the UDP/IPv4/Ethernet transmitter
package udp_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CSUM1,
        S_CSUM2,
        S_PREAMBLE,
        S_SFD,
        S_ETH_HDR,
        S_IP_HDR,
        S_UDP_HDR,
        S_PAYLOAD,
        S_PAD,
        S_FCS,
        S_IFG
    } udp_state_e;

    localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
    localparam logic [7:0]  PROTO_UDP       = 8'h11;
    localparam logic [7:0]  PREAMBLE        = 8'h55;
    localparam logic [7:0]  SFD             = 8'hD5;
    localparam logic [10:0] MAX_PAYLOAD     = 11'd1472;
    localparam logic [10:0] MIN_ETH_PAYLOAD = 11'd46;
    localparam logic [10:0] IFG_CYCLES      = 11'd12;
    localparam logic [10:0] IP_UDP_HDR_LEN  = 11'd28;
    localparam logic [31:0] CRC_POLY        = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;

endpackage

// File: rtl/crc32_eth.sv
// rtl/crc32_eth.sv - byte-wise reflected Ethernet CRC-32 accumulator (raw register, not inverted)
module crc32_eth
    import udp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (en) begin
            crc_d = crc_q ^ {24'd0, data};
            for (int i = 0; i < 8; i++) begin
                crc_d = crc_d[0] ? ((crc_d >> 1) ^ CRC_POLY) : (crc_d >> 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || init) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/udp_tx.sv
// rtl/udp_tx.sv - builds and streams one UDP/IPv4/Ethernet frame per start request
module udp_tx
    import udp_pkg::*;
#(
    parameter logic [47:0] SRC_MAC  = 48'h02_00_00_00_00_01,
    parameter logic [47:0] DST_MAC  = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [31:0] SRC_IP   = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter logic [31:0] DST_IP   = {8'd192, 8'd168, 8'd1, 8'd20},
    parameter logic [15:0] SRC_PORT = 16'd5000,
    parameter logic [15:0] DST_PORT = 16'd5001,
    parameter logic [7:0]  TTL      = 8'd64
) (
    input  logic        main_clk,
    input  logic        main_rst,
    input  logic        start,
    input  logic [10:0] tx_len,
    input  logic [7:0]  pay_byte,
    input  logic        pay_valid,
    output logic        pay_ready,
    output logic [7:0]  eth_byte,
    output logic        eth_valid,
    input  logic        eth_ready,
    output logic        busy,
    output logic        done,
    output logic        len_err
);

    // Header words that never change; only total_len and ident are added per frame.
    localparam logic [19:0] CONST_SUM = 20'h04500 + 20'h04000
                                      + {4'd0, TTL, PROTO_UDP}
                                      + {4'd0, SRC_IP[31:16]} + {4'd0, SRC_IP[15:0]}
                                      + {4'd0, DST_IP[31:16]} + {4'd0, DST_IP[15:0]};
    localparam logic [10:0] PAD_LIMIT = MIN_ETH_PAYLOAD - IP_UDP_HDR_LEN;

    udp_state_e   state_q, state_d;
    logic [10:0]  cnt_q, cnt_d;
    logic [10:0]  len_q, len_d;
    logic [19:0]  sum_q, sum_d;
    logic [335:0] hdr_q, hdr_d;
    logic [7:0]   eth_byte_q, eth_byte_d;
    logic         eth_valid_q, eth_valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         len_err_q, len_err_d;
    logic [15:0]  ident_q, ident_d;

    logic         adv;
    logic [15:0]  total_len;
    logic [15:0]  udp_len;
    logic [16:0]  fold1;
    logic [15:0]  fold2;
    logic [15:0]  ip_csum;
    logic [31:0]  crc_val;
    logic [31:0]  crc_fcs;
    logic         crc_init;
    logic         crc_en;
    logic [7:0]   crc_data;

    crc32_eth u_crc (
        .clk  (main_clk),
        .rst  (main_rst),
        .init (crc_init),
        .en   (crc_en),
        .data (crc_data),
        .crc  (crc_val)
    );

    always_comb begin
        adv       = !eth_valid_q || eth_ready;
        total_len = {5'd0, len_q} + {5'd0, IP_UDP_HDR_LEN};
        udp_len   = {5'd0, len_q} + 16'd8;
        fold1     = {1'b0, sum_q[15:0]} + {13'd0, sum_q[19:16]};
        fold2     = fold1[15:0] + {15'd0, fold1[16]};
        ip_csum   = ~fold2;
        crc_fcs   = ~crc_val;

        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        sum_d       = sum_q;
        hdr_d       = hdr_q;
        eth_byte_d  = eth_byte_q;
        eth_valid_d = eth_valid_q;
        done_d      = 1'b0;
        len_err_d   = 1'b0;
        ident_d     = ident_q;
        crc_init    = 1'b0;
        crc_en      = 1'b0;

        // A slot that is free and not refilled below becomes a bubble.
        if (adv) eth_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (tx_len != 11'd0 && tx_len <= MAX_PAYLOAD) begin
                        len_d    = tx_len;
                        crc_init = 1'b1;
                        state_d  = S_CSUM1;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            S_CSUM1: begin
                sum_d   = CONST_SUM + {4'd0, total_len} + {4'd0, ident_q};
                state_d = S_CSUM2;
            end
            S_CSUM2: begin
                hdr_d = {DST_MAC, SRC_MAC, ETHERTYPE_IPV4,
                         8'h45, 8'h00, total_len, ident_q, 16'h4000, TTL, PROTO_UDP,
                         ip_csum, SRC_IP, DST_IP,
                         SRC_PORT, DST_PORT, udp_len, 16'h0000};
                cnt_d   = '0;
                state_d = S_PREAMBLE;
            end
            S_PREAMBLE: begin
                if (adv) begin
                    eth_byte_d  = PREAMBLE;
                    eth_valid_d = 1'b1;
                    cnt_d       = cnt_q + 11'd1;
                    if (cnt_q == 11'd6) begin
                        cnt_d   = '0;
                        state_d = S_SFD;
                    end
                end
            end
            S_SFD: begin
                if (adv) begin
                    eth_byte_d  = SFD;
                    eth_valid_d = 1'b1;
                    state_d     = S_ETH_HDR;
                end
            end
            S_ETH_HDR, S_IP_HDR, S_UDP_HDR: begin
                if (adv) begin
                    eth_byte_d  = hdr_q[335:328];
                    eth_valid_d = 1'b1;
                    crc_en      = 1'b1;
                    hdr_d       = {hdr_q[327:0], 8'h00};
                    cnt_d       = cnt_q + 11'd1;
                    if (state_q == S_ETH_HDR && cnt_q == 11'd13) begin
                        cnt_d   = '0;
                        state_d = S_IP_HDR;
                    end else if (state_q == S_IP_HDR && cnt_q == 11'd19) begin
                        cnt_d   = '0;
                        state_d = S_UDP_HDR;
                    end else if (state_q == S_UDP_HDR && cnt_q == 11'd7) begin
                        cnt_d   = '0;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (adv && pay_valid) begin
                    eth_byte_d  = pay_byte;
                    eth_valid_d = 1'b1;
                    crc_en      = 1'b1;
                    cnt_d       = cnt_q + 11'd1;
                    if (cnt_q == len_q - 11'd1) begin
                        // Short payloads keep counting through PAD up to the 46-byte minimum.
                        if (len_q < PAD_LIMIT) begin
                            state_d = S_PAD;
                        end else begin
                            cnt_d   = '0;
                            state_d = S_FCS;
                        end
                    end
                end
            end
            S_PAD: begin
                if (adv) begin
                    eth_byte_d  = 8'h00;
                    eth_valid_d = 1'b1;
                    crc_en      = 1'b1;
                    cnt_d       = cnt_q + 11'd1;
                    if (cnt_q == PAD_LIMIT - 11'd1) begin
                        cnt_d   = '0;
                        state_d = S_FCS;
                    end
                end
            end
            S_FCS: begin
                if (adv) begin
                    eth_byte_d  = crc_fcs[{cnt_q[1:0], 3'b000} +: 8];
                    eth_valid_d = 1'b1;
                    cnt_d       = cnt_q + 11'd1;
                    if (cnt_q == 11'd3) begin
                        cnt_d   = '0;
                        state_d = S_IFG;
                    end
                end
            end
            S_IFG: begin
                if (eth_valid_q) begin
                    if (eth_ready) begin
                        done_d  = 1'b1;
                        ident_d = ident_q + 16'd1;
                    end
                end else if (cnt_q == IFG_CYCLES - 11'd1) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d   = (state_d != S_IDLE);
        crc_data = eth_byte_d;
    end

    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            sum_q       <= '0;
            hdr_q       <= '0;
            eth_byte_q  <= 8'h00;
            eth_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            len_err_q   <= 1'b0;
            ident_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            hdr_q       <= hdr_d;
            eth_byte_q  <= eth_byte_d;
            eth_valid_q <= eth_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            len_err_q   <= len_err_d;
            ident_q     <= ident_d;
        end
    end

    assign pay_ready = (state_q == S_PAYLOAD) && adv;
    assign eth_byte  = eth_byte_q;
    assign eth_valid = eth_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_udp_tx.sv
// tb/tb_udp_tx.sv - self-checking bench for udp_tx against a byte-level frame model
module tb_udp_tx;

    localparam logic [47:0] B_SRC_MAC  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] B_DST_MAC  = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [31:0] B_SRC_IP   = {8'd192, 8'd168, 8'd1, 8'd10};
    localparam logic [31:0] B_DST_IP   = {8'd192, 8'd168, 8'd1, 8'd20};
    localparam logic [15:0] B_SRC_PORT = 16'd5000;
    localparam logic [15:0] B_DST_PORT = 16'd5001;
    localparam logic [7:0]  B_TTL      = 8'd64;

    logic        main_clk;
    logic        main_rst;
    logic        start;
    logic [10:0] tx_len;
    logic [7:0]  pay_byte;
    logic        pay_valid;
    logic        pay_ready;
    logic [7:0]  eth_byte;
    logic        eth_valid;
    logic        eth_ready;
    logic        busy;
    logic        done;
    logic        len_err;

    int tests;
    int fails;
    int last_dcnt;
    int last_stall_bad;
    int last_ifg;
    bit aborted;
    logic [15:0] exp_ident;

    logic [7:0] payload [0:1471];
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] body_q [$];
    logic [7:0] ref_q [$];

    udp_tx dut (
        .main_clk  (main_clk),
        .main_rst  (main_rst),
        .start     (start),
        .tx_len    (tx_len),
        .pay_byte  (pay_byte),
        .pay_valid (pay_valid),
        .pay_ready (pay_ready),
        .eth_byte  (eth_byte),
        .eth_valid (eth_valid),
        .eth_ready (eth_ready),
        .busy      (busy),
        .done      (done),
        .len_err   (len_err)
    );

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_be(input logic [47:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) body_q.push_back(v[8*i +: 8]);
    endtask

    task automatic build_expected(input int len, input logic [15:0] id);
        int sum;
        logic [15:0] ck;
        logic [31:0] crc;
        exp_q.delete();
        body_q.delete();
        push_be(B_DST_MAC, 6);
        push_be(B_SRC_MAC, 6);
        push_be(48'h0800, 2);
        push_be(48'h4500, 2);
        push_be({32'd0, 16'(len + 28)}, 2);
        push_be({32'd0, id}, 2);
        push_be(48'h4000, 2);
        push_be({32'd0, B_TTL, 8'h11}, 2);
        push_be(48'h0, 2);
        push_be({16'd0, B_SRC_IP}, 4);
        push_be({16'd0, B_DST_IP}, 4);
        sum = 0;
        for (int i = 14; i < 34; i += 2) sum += int'({body_q[i], body_q[i+1]});
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        ck = ~16'(sum);
        body_q[24] = ck[15:8];
        body_q[25] = ck[7:0];
        push_be({32'd0, B_SRC_PORT}, 2);
        push_be({32'd0, B_DST_PORT}, 2);
        push_be({32'd0, 16'(len + 8)}, 2);
        push_be(48'h0, 2);
        for (int i = 0; i < len; i++) body_q.push_back(payload[i]);
        for (int i = len; i < 18; i++) body_q.push_back(8'h00);
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        crc = 32'hFFFFFFFF;
        foreach (body_q[i]) begin
            exp_q.push_back(body_q[i]);
            crc = crc ^ {24'd0, body_q[i]};
            for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
        end
        crc = ~crc;
        for (int k = 0; k < 4; k++) exp_q.push_back(crc[8*k +: 8]);
    endtask

    task automatic run_frame(input int len, input bit stall_en, input int rst_at);
        int cyc;
        int pidx;
        int dq;
        bit fin;
        bit held;
        logic [7:0] held_byte;
        got_q.delete();
        pidx = 0; cyc = 0; dq = 0; fin = 1'b0; held = 1'b0; held_byte = 8'h00;
        last_dcnt = 0; last_stall_bad = 0; last_ifg = 0; aborted = 1'b0;
        @(negedge main_clk);
        start = 1'b1; tx_len = len[10:0]; pay_valid = 1'b0; eth_ready = 1'b1;
        @(negedge main_clk);
        start = 1'b0;
        #1;
        chk("busy_after_start", 32'(busy), 32'd1);
        while (!fin && !aborted && cyc < 8000) begin
            @(negedge main_clk);
            eth_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            pay_valid = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            pay_byte  = (pidx < len) ? payload[pidx] : 8'h00;
            // Requests while busy (including the done cycle) must be dropped.
            start     = stall_en && busy;
            if (stall_en) tx_len = 11'($urandom_range(0, 2047));
            #1;
            if (held && !(eth_valid === 1'b1 && eth_byte === held_byte)) last_stall_bad++;
            held = eth_valid && !eth_ready;
            held_byte = eth_byte;
            if (eth_valid && eth_ready) got_q.push_back(eth_byte);
            if (pay_valid && pay_ready) pidx++;
            if (done) last_dcnt++;
            if (last_dcnt > 0 && busy) last_ifg++;
            if (last_dcnt > 0 && !busy) fin = 1'b1;
            if (rst_at >= 0 && pidx == rst_at) aborted = 1'b1;
            cyc++;
        end
        start = 1'b0;
        pay_valid = 1'b0;
        eth_ready = 1'b1;
        if (aborted) begin
            @(negedge main_clk);
            main_rst = 1'b1;
            @(negedge main_clk);
            main_rst = 1'b0;
            #1;
            chk("abort_eth_valid", 32'(eth_valid), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            repeat (30) begin
                @(negedge main_clk);
                #1;
                if (done || eth_valid) dq++;
            end
            chk("abort_no_done", 32'(dq + last_dcnt), 32'd0);
        end else begin
            chk("frame_complete", 32'(fin), 32'd1);
        end
    endtask

    task automatic check_frame(input string tag, input int len);
        int bad;
        int first;
        int n;
        build_expected(len, exp_ident);
        chk({tag, "_size"}, 32'(got_q.size()), 32'(exp_q.size()));
        bad = 0;
        first = 0;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = n - 1; i >= 0; i--) begin
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                first = i;
            end
        end
        tests++;
        assert (bad == 0) else begin
            fails++;
            $error("FAIL %s_bytes: %0d wrong, first at %0d observed 0x%02h expected 0x%02h",
                   tag, bad, first, got_q[first], exp_q[first]);
        end
        chk({tag, "_done_once"}, 32'(last_dcnt), 32'd1);
        chk({tag, "_stall_stable"}, 32'(last_stall_bad), 32'd0);
        chk({tag, "_ifg"}, 32'(last_ifg), 32'd12);
        exp_ident = exp_ident + 16'd1;
    endtask

    task automatic bad_len(input int len);
        int ev;
        @(negedge main_clk);
        start = 1'b1;
        tx_len = len[10:0];
        @(negedge main_clk);
        start = 1'b0;
        #1;
        chk("len_err_pulse", 32'(len_err), 32'd1);
        chk("len_err_busy", 32'(busy), 32'd0);
        ev = 0;
        repeat (20) begin
            @(negedge main_clk);
            #1;
            if (eth_valid || busy || len_err) ev++;
        end
        chk("len_err_quiet", 32'(ev), 32'd0);
    endtask

    initial begin
        int hsum;
        int diff;
        tests = 0; fails = 0; exp_ident = 16'd0;
        main_rst = 1'b1; start = 1'b0; tx_len = '0; pay_byte = 8'h00;
        pay_valid = 1'b0; eth_ready = 1'b1;
        repeat (3) @(negedge main_clk);
        #1;
        chk("rst_eth_valid", 32'(eth_valid), 32'd0);
        chk("rst_pay_ready", 32'(pay_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);
        chk("rst_eth_byte", 32'(eth_byte), 32'd0);
        main_rst = 1'b0;

        for (int i = 0; i < 18; i++) payload[i] = 8'(i);
        run_frame(18, 1'b0, -1);
        check_frame("f18", 18);
        chk("f18_ethertype", 32'({got_q[20], got_q[21]}), 32'h0800);
        chk("f18_total_len", 32'({got_q[24], got_q[25]}), 32'h002E);
        chk("f18_udp_len", 32'({got_q[46], got_q[47]}), 32'h001A);

        payload[0] = 8'hAB;
        run_frame(1, 1'b0, -1);
        check_frame("f1", 1);
        chk("f1_ident", 32'({got_q[26], got_q[27]}), 32'd1);
        chk("f1_last_pad", 32'(got_q[67]), 32'd0);

        for (int i = 0; i < 1472; i++) payload[i] = 8'($urandom);
        run_frame(1472, 1'b0, -1);
        check_frame("f1472", 1472);
        chk("f1472_total_len", 32'({got_q[24], got_q[25]}), 32'h05DC);
        hsum = 0;
        for (int i = 0; i < 10; i++) hsum += int'({got_q[22 + 2*i], got_q[23 + 2*i]});
        while (hsum > 32'hFFFF) hsum = (hsum & 32'hFFFF) + (hsum >> 16);
        chk("f1472_hdr_sum", 32'(hsum), 32'hFFFF);

        bad_len(0);
        bad_len(1473);

        for (int i = 0; i < 64; i++) payload[i] = 8'($urandom);
        run_frame(64, 1'b0, -1);
        check_frame("f64", 64);
        ref_q = got_q;
        run_frame(64, 1'b1, -1);
        check_frame("f64_stall", 64);
        diff = 0;
        for (int i = 50; i < 114; i++) if (got_q[i] !== ref_q[i]) diff++;
        chk("f64_stall_payload_same", 32'(diff), 32'd0);

        for (int i = 0; i < 40; i++) payload[i] = 8'($urandom);
        run_frame(40, 1'b0, 10);
        chk("abort_taken", 32'(aborted), 32'd1);
        exp_ident = 16'd0;
        run_frame(40, 1'b0, -1);
        check_frame("after_rst", 40);
        chk("after_rst_ident", 32'({got_q[26], got_q[27]}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
